// File: rtl/klingon_pkg.sv
// Shared definitions for the Klingon numeral reader: glyph table, digit type
// and FSM state encoding.
package klingon_pkg;

    // Segment pattern of each Klingon numeral glyph, indexed by digit value.
    localparam logic [6:0] KLINGON_GLYPH [10] = '{
        7'h41, 7'h08, 7'h14, 7'h1C, 7'h63,
        7'h36, 7'h2A, 7'h49, 7'h5D, 7'h77
    };

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

endpackage

// File: rtl/klingon_glyph_decode.sv
// Combinational glyph decoder: exact match against the glyph table.
module klingon_glyph_decode
    import klingon_pkg::*;
(
    input  logic [6:0] glyph,
    output digit_t     digit,
    output logic       hit
);

    // Search the table; any pattern not listed is reported as a miss.
    always_comb begin
        digit = '0;
        hit   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (glyph == KLINGON_GLYPH[i]) begin
                digit = 4'(i);
                hit   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/klingon_reader.sv
// Klingon numeral reader: accumulates glyphs into a BCD number and presents
// the result until the consumer takes it.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both 1; valid-side signals are held stable by the producer until then, and
// ready never depends combinationally on valid.
module klingon_reader
    import klingon_pkg::*;
#(
    parameter int MAX_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              in_glyph,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [4*MAX_DIGITS-1:0] out_bcd,
    output logic [2:0]              out_count,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output state_t                  fsm_state
);

    localparam int         W       = 4 * MAX_DIGITS;
    localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

    state_t         state;
    state_t         state_next;
    digit_t         digit;
    logic           hit;
    logic           accept;
    logic           reject;
    logic [W-1:0]   shifted;

    klingon_glyph_decode u_decode (
        .glyph (in_glyph),
        .digit (digit),
        .hit   (hit)
    );

    assign accept    = in_valid && in_ready;
    // A glyph is refused if it is unknown or there is no room left for it.
    assign reject    = !hit || (out_count == MAX_CNT);
    assign shifted   = (out_bcd << 4) | W'(digit);
    assign fsm_state = state;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_COLLECT: begin
                if (accept) begin
                    if (in_last)     state_next = ST_HOLD;
                    else if (reject) state_next = ST_DRAIN;
                    else             state_next = ST_COLLECT;
                end
            end
            ST_DRAIN: begin
                if (accept && in_last) state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = (state != ST_HOLD);
        out_valid = (state == ST_HOLD);
    end

    // Accumulator: append digits, collapse to an error result, clear on take.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_bcd   <= '0;
            out_count <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_COLLECT: begin
                    if (accept) begin
                        if (reject) begin
                            out_bcd   <= '0;
                            out_count <= '0;
                            out_err   <= 1'b1;
                        end else begin
                            out_bcd   <= shifted;
                            out_count <= out_count + 3'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_bcd   <= '0;
                        out_count <= '0;
                        out_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_klingon_reader.sv
// Self-checking bench for klingon_reader with a numeric reference model.
module tb_klingon_reader;
    import klingon_pkg::*;

    localparam int MAXD = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [6:0]      in_glyph;
    logic            in_valid;
    logic            in_last;
    logic            in_ready;
    logic [4*MAXD-1:0] out_bcd;
    logic [2:0]      out_count;
    logic            out_err;
    logic            out_valid;
    logic            out_ready;
    state_t          fsm_state;

    int tests  = 0;
    int failed = 0;

    logic [6:0]  glyph_q[$];
    logic [15:0] exp_q[$];

    klingon_reader #(.MAX_DIGITS(MAXD)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_glyph  (in_glyph),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_bcd   (out_bcd),
        .out_count (out_count),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fsm_state (fsm_state)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present one glyph for one cycle; the bench always stands at a negedge.
    task automatic send(input logic [6:0] g, input logic last);
        in_glyph = g;
        in_last  = last;
        in_valid = 1'b1;
        check("in_ready_on_send", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_glyph = 7'($urandom);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_ready"}, 32'(in_ready),  32'd1);
        check({tag, "_bcd"},   32'(out_bcd),   32'd0);
        check({tag, "_count"}, 32'(out_count), 32'd0);
        check({tag, "_err"},   32'(out_err),   32'd0);
    endtask

    // Reference model: the number is the digits read left to right; any
    // unknown glyph or more than MAXD glyphs gives an error with zero value.
    task automatic model(output logic [15:0] e_bcd, output int e_cnt,
                         output logic e_err);
        int value;
        int found;
        value = 0;
        e_err = 1'b0;
        foreach (glyph_q[i]) begin
            found = -1;
            for (int d = 0; d < 10; d++)
                if (glyph_q[i] == KLINGON_GLYPH[d]) found = d;
            if (found < 0) e_err = 1'b1;
            else           value = value * 16 + found;
        end
        if (glyph_q.size() > MAXD) e_err = 1'b1;
        e_bcd = e_err ? 16'd0 : 16'(value);
        e_cnt = e_err ? 0 : glyph_q.size();
    endtask

    // Feed glyph_q as one number, check the result, stall, then take it.
    task automatic run_number(input string tag, input int hold, input bit gaps);
        logic [15:0] e_bcd;
        int          e_cnt;
        logic        e_err;
        int          waited;
        model(e_bcd, e_cnt, e_err);
        exp_q.push_back(e_bcd);
        foreach (glyph_q[i]) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send(glyph_q[i], i == glyph_q.size() - 1);
        end
        waited = 0;
        while (!out_valid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_latency"},   32'(waited),    32'd0);
        check({tag, "_bcd"},       32'(out_bcd),   32'(exp_q.pop_front()));
        check({tag, "_count"},     32'(out_count), 32'(e_cnt));
        check({tag, "_err"},       32'(out_err),   32'(e_err));
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        for (int k = 0; k < hold; k++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_last   = 1'(k & 1);
            in_glyph  = KLINGON_GLYPH[$urandom_range(0, 9)];
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_ready"}, 32'(in_ready),  32'd0);
            check({tag, "_hold_bcd"},   32'(out_bcd),   32'(e_bcd));
            check({tag, "_hold_count"}, 32'(out_count), 32'(e_cnt));
            check({tag, "_hold_err"},   32'(out_err),   32'(e_err));
        end
        // Handshake cycle with a glyph offered: it must not be taken.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        in_glyph  = KLINGON_GLYPH[$urandom_range(0, 9)];
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        check_cleared({tag, "_after"});
        glyph_q.delete();
    endtask

    initial begin
        int len;
        reset     = 1'b1;
        in_glyph  = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_cleared("reset");

        // 3,1,4 consumed immediately.
        glyph_q = '{KLINGON_GLYPH[3], KLINGON_GLYPH[1], KLINGON_GLYPH[4]};
        run_number("n314", 0, 0);

        // Single 7 held for five cycles.
        glyph_q = '{KLINGON_GLYPH[7]};
        run_number("n7_hold", 5, 0);

        // Invalid glyph mid-number.
        glyph_q = '{KLINGON_GLYPH[2], 7'h7F, KLINGON_GLYPH[5], KLINGON_GLYPH[6]};
        run_number("bad_glyph", 1, 0);

        // Invalid glyph as the final glyph.
        glyph_q = '{KLINGON_GLYPH[8], 7'h00};
        run_number("bad_last", 0, 0);

        // Overflow: five glyphs.
        glyph_q = '{KLINGON_GLYPH[1], KLINGON_GLYPH[2], KLINGON_GLYPH[3],
                    KLINGON_GLYPH[4], KLINGON_GLYPH[5]};
        run_number("overflow", 0, 0);

        // Exactly MAXD glyphs, the largest legal number.
        glyph_q = '{KLINGON_GLYPH[9], KLINGON_GLYPH[8], KLINGON_GLYPH[7],
                    KLINGON_GLYPH[6]};
        run_number("full", 0, 1);

        // Reset mid-number discards the partial result.
        send(KLINGON_GLYPH[5], 1'b0);
        send(KLINGON_GLYPH[6], 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_cleared("reset_mid");
        glyph_q = '{KLINGON_GLYPH[9]};
        run_number("after_reset", 0, 0);

        // Reset while holding a result.
        send(KLINGON_GLYPH[4], 1'b1);
        check("hold_before_reset", 32'(out_valid), 32'd1);
        reset = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check_cleared("reset_hold");

        // Every glyph as a single-digit number.
        for (int d = 0; d < 10; d++) begin
            glyph_q = '{KLINGON_GLYPH[d]};
            run_number("single", 0, 0);
        end

        // Random numbers with idle gaps, stalls and occasional bad glyphs.
        for (int n = 0; n < 40; n++) begin
            len = $urandom_range(1, MAXD + 2);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 9) == 0) glyph_q.push_back(7'($urandom));
                else glyph_q.push_back(KLINGON_GLYPH[$urandom_range(0, 9)]);
            end
            run_number("random", $urandom_range(0, 3), 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/klingon_reader.md
KLINGON_READER -- requirements
Module: klingon_reader

Interface
REQ-001 Parameter MAX_DIGITS, default 4: maximum glyphs per number; legal range 1..7.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_glyph  input  7  segment pattern of one Klingon glyph, bit order as the team's klingon_behavioral encoder output.
REQ-005 in_valid  input  1  in_glyph/in_last are valid this cycle.
REQ-006 in_last  input  1  current glyph is the final glyph of the number.
REQ-007 in_ready  output  1  reader accepts a glyph this cycle; transfer occurs when in_valid && in_ready.
REQ-008 out_bcd  output  4*MAX_DIGITS  assembled number in BCD; most recent digit in bits [3:0].
REQ-009 out_count  output  3  number of digits in out_bcd.
REQ-010 out_err  output  1  number contained an invalid glyph or overflowed.
REQ-011 out_valid  output  1  out_bcd/out_count/out_err are valid and stable.
REQ-012 out_ready  input  1  consumer takes result; transfer occurs when out_valid && out_ready.

Function
REQ-013 Decode SHALL be an exact match of in_glyph against KLINGON_GLYPH[0..9]; any other pattern is invalid.
REQ-014 FSM states SHALL be IDLE, COLLECT, DRAIN, HOLD.
REQ-015 in_ready SHALL be 1 in IDLE, COLLECT, DRAIN and 0 in HOLD; out_valid SHALL be 1 only in HOLD.
REQ-016 On an accepted valid glyph in IDLE/COLLECT with count < MAX_DIGITS: out_bcd <= {out_bcd[4*MAX_DIGITS-5:0], digit}, count += 1.
REQ-017 IDLE -> COLLECT on an accepted valid glyph with in_last=0; COLLECT stays in COLLECT on further such glyphs.
REQ-018 An accepted valid glyph with in_last=1 from IDLE/COLLECT SHALL be appended and move to HOLD; out_valid asserts the next cycle.
REQ-019 An accepted invalid glyph, or an accepted glyph when count == MAX_DIGITS, SHALL set err and clear out_bcd/out_count to 0.
REQ-020 After such an error: with in_last=1 go to HOLD; otherwise go to DRAIN.
REQ-021 DRAIN SHALL discard glyphs, valid or not, until a glyph with in_last=1 is accepted, then go to HOLD with out_err=1, out_bcd=0, out_count=0.
REQ-022 In HOLD, outputs SHALL be held constant while out_ready=0.
REQ-023 A HOLD handshake SHALL clear out_bcd, out_count and err, and return to IDLE; no glyph is accepted in that cycle.
REQ-024 A cycle with in_valid=0 SHALL change no state.
REQ-025 Throughput SHALL be one glyph per cycle in IDLE/COLLECT/DRAIN.

Reset
REQ-026 Reset SHALL force IDLE, out_bcd=0, out_count=0, out_err=0, out_valid=0, in_ready=1 on the next edge.
REQ-027 Reset SHALL take priority over every handshake, including mid-number and in HOLD; the partial result is discarded.

Structure
REQ-028 Package klingon_pkg SHALL hold KLINGON_GLYPH[0..9], the 4-bit digit type and the FSM state encoding, shared with klingon_behavioral.
REQ-029 Sub-module klingon_glyph_decode SHALL be purely combinational (glyph -> digit, hit); the FSM and accumulator reside in klingon_reader.

Verification
REQ-030 Glyphs 3, 1, 4 with in_last on 4, out_ready=1 -> out_bcd=16'h0314, out_count=3, out_err=0, one out_valid pulse.
REQ-031 Glyph 7 with in_last, out_ready=0 for 5 cycles -> outputs stable, in_ready=0 throughout; then out_ready=1 -> return to IDLE.
REQ-032 Glyphs 2, 7'h7F, 5, 6 (last) -> out_err=1, out_bcd=0, out_count=0 after the final glyph.
REQ-033 Five valid glyphs with in_last on the fifth, MAX_DIGITS=4 -> out_err=1, out_count=0.
REQ-034 Reset after 2 glyphs, then glyph 9 (last) -> out_bcd=16'h0009, out_count=1.
REQ-035 Exhaustive pass: each glyph 0..9 as a single-digit number -> out_bcd equals the digit, matching klingon_behavioral in a loopback.
